pipe_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipe: load-use stall, branch flush, data-memory freeze.
// Optional saturating perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_MemRead,
  input  logic              EX_MEM_Branch,
  input  logic              EX_MEM_Zero,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              Flush,
  output logic              PC_Sel_Branch,
  output logic              Pipe_Hold,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       err_set;
  logic       mem_stall;
  logic       load_use;
  logic       branch_taken;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_rd != '0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
  assign branch_taken = EX_MEM_Branch && EX_MEM_Zero;

  always_comb begin
    // NOTE: every output and next-state term gets a default first so no path leaves one unassigned (no latches).
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    Flush         = 1'b0;
    PC_Sel_Branch = 1'b0;
    Pipe_Hold     = 1'b0;
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    fcnt_nxt      = fcnt;
    err_set       = 1'b0;
    mem_stall     = 1'b0;
    // Outputs are forced to their idle values for as long as reset is held.
    if (reset) begin
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          mem_stall = (state == ST_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
          if (mem_stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
            if (state == ST_RUN) begin
              state_nxt = ST_MEM_WAIT;
              wcnt_nxt  = 8'd1;
            end else begin
              wcnt_nxt = wcnt + 8'd1;
              if (wcnt_nxt == TIMEOUT) begin
                err_set   = 1'b1;
                state_nxt = ST_RUN;
              end
            end
          end else begin
            state_nxt = ST_RUN;
            if (branch_taken) begin
              PC_Sel_Branch = 1'b1;
              Flush         = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = 3'd1;
              end
            end else if (load_use) begin
              PC_Write     = 1'b0;
              IF_ID_Write  = 1'b0;
              ID_EX_Bubble = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Memory requests and hazards seen here belong to squashed instructions.
          Flush    = 1'b1;
          fcnt_nxt = fcnt + 3'd1;
          if (fcnt_nxt == FLUSH_LEN) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state   <= ST_RUN;
      wcnt    <= '0;
      fcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      fcnt  <= fcnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // PC_Sel_Branch is high exactly once per taken branch, so it doubles as the flush event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_Write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (PC_Sel_Branch && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
